// File: rtl/uart_rx_deser_pkg.sv
// Shared UART receiver definitions: FSM states, default timing, vote helper.
package uart_rx_deser_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
    localparam int DEFAULT_MAJ_OFFSET   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // 2-of-3 majority used to de-noise each bit sample
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deser_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rxd pin; resets to the idle level (1).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Preset to 1 so a reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: mid-bit 3-sample majority vote, false-start rejection,
// framing-error detection and break handling. Feeds cmd_parser directly.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // even, >= 8
    parameter int MAJ_OFFSET   = DEFAULT_MAJ_OFFSET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_data_ready,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT / 2 - MAJ_OFFSET);
    localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_VOTE = CW'(CLKS_PER_BIT / 2 + MAJ_OFFSET);

    rx_state_t     state;
    logic          rxd_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [1:0]    samp;     // early and mid samples; the late one is rxd_s itself
    logic          vote;
    logic          at_vote;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign vote    = maj3(samp[0], samp[1], rxd_s);
    assign at_vote = (bit_cnt == CNT_VOTE);
    assign rx_busy = (state != ST_IDLE);

    // Receive FSM with bit timer, sample capture, shift register and output pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            samp           <= 2'b11;
            rxd_data       <= '0;
            rxd_data_ready <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            rxd_data_ready <= 1'b0;
            framing_error  <= 1'b0;

            // Free-running bit timer; IDLE and BREAK override it below
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == CNT_S0) samp[0] <= rxd_s;
            if (bit_cnt == CNT_S1) samp[1] <= rxd_s;

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (!rxd_s) state <= ST_START;
                end
                ST_START: begin
                    if (at_vote) begin
                        if (vote) begin
                            state <= ST_IDLE;       // glitch, not a real start bit
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (at_vote) begin
                        shreg <= {vote, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (at_vote) begin
                        if (vote) begin
                            // Leave mid-stop-bit so a back-to-back start edge is caught
                            rxd_data       <= shreg;
                            rxd_data_ready <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            bit_cnt       <= '0;
                            state         <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Need one full bit time of continuous idle before re-arming
                    if (!rxd_s)                    bit_cnt <= '0;
                    else if (bit_cnt == CNT_LAST)  state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomised scoreboard bench for uart_rx_deser: stimulus pushes expected
// bytes / framing errors, an independent monitor pops on every DUT pulse.
module tb_uart_rx_deser;

    localparam int CPB = 104;
    localparam int MAJ = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic       framing_error;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int   fe_exp = 0;
    int   pushed = 0;
    int   ready_cnt = 0;
    int   fe_cnt = 0;
    int   first_ready_cyc = -1;
    logic prev_ready = 1'b0;
    logic prev_fe = 1'b0;

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .MAJ_OFFSET(MAJ)) dut (
        .clk            (clk),
        .reset          (reset),
        .rxd            (rxd),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .framing_error  (framing_error),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference framing: start 0, 8 data LSB first, stop. A good stop bit
    // yields the byte; a low stop bit yields one framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (stop_ok) begin
            exp_q.push_back(b);
            pushed++;
        end else begin
            fe_exp++;
        end
        drive_bit(stop_ok, CPB);
    endtask

    // Monitor: every pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (rxd_data_ready) begin
                chk("ready_fe_overlap", framing_error, 0);
                chk("ready_two_cycles", prev_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got %0h expected no pulse", rxd_data);
                end else begin
                    chk("rxd_data", rxd_data, exp_q.pop_front());
                end
                if (first_ready_cyc < 0) first_ready_cyc = cyc;
                ready_cnt++;
            end
            if (framing_error) begin
                chk("fe_two_cycles", prev_fe, 0);
                if (fe_exp == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_framing_error: got 1 expected 0");
                end else begin
                    fe_exp--;
                end
                fe_cnt++;
            end
        end
        prev_ready = rxd_data_ready;
        prev_fe    = framing_error;
    end

    initial begin
        logic [7:0] hash [17];
        logic [7:0] b;
        int t0;
        int busy;
        int glen;

        repeat (4) @(negedge clk);
        chk("reset_rxd_data", rxd_data, 8'h00);
        chk("reset_ready", rxd_data_ready, 0);
        chk("reset_fe", framing_error, 0);
        chk("reset_busy", rx_busy, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // The first clk edge sampling the low line is t0+1; ready follows
        // 993 clks after that edge, so it is seen at cycle t0+994.
        t0 = cyc;
        send_byte(8'h55, 1'b1);
        chk("first_latency", first_ready_cyc - t0, 994);
        send_byte(8'hA2, 1'b1);
        drive_bit(1'b1, CPB);

        // set-hash command, back-to-back frames
        hash[0] = 8'h01; hash[1] = 8'hA2; hash[2] = 8'h00; hash[3] = 8'h4F;
        for (int i = 4; i < 17; i++) hash[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 17; i++) send_byte(hash[i], 1'b1);
        drive_bit(1'b1, 2 * CPB);
        chk("hash_ready_count", ready_cnt, 19);
        chk("hash_no_fe", fe_cnt, 0);

        // Low glitches shorter than the first sample point are rejected
        for (int g = 0; g < 4; g++) begin
            glen = (g == 0) ? 40 : int'($urandom_range(1, 45));
            busy = 0;
            rxd = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (i == glen) rxd = 1'b1;
                @(negedge clk);
                if (rx_busy) busy++;
            end
            chk("glitch_busy_seen", int'(busy > 0), 1);
            chk("glitch_busy_max", int'(busy <= 55), 1);
            chk("glitch_busy_end", rx_busy, 0);
        end

        // Bad stop bit: one framing error, data held, next byte fine
        send_byte(8'h33, 1'b0);
        drive_bit(1'b1, 2 * CPB);
        chk("fe_data_held", rxd_data, hash[16]);
        chk("fe_busy_end", rx_busy, 0);
        send_byte(8'h03, 1'b1);
        drive_bit(1'b1, CPB);

        // Break: long low line, one framing error, then 104 idle clks to leave
        fe_exp++;
        drive_bit(1'b0, 3000);
        chk("break_busy_low", rx_busy, 1);
        drive_bit(1'b1, 100);
        chk("break_busy_before_idle", rx_busy, 1);
        drive_bit(1'b1, 10);
        chk("break_busy_after_idle", rx_busy, 0);
        chk("break_fe_count", fe_cnt, 2);

        // Reset during bit 4 of 0x6F abandons the frame
        b = 8'h6F;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], 50);
        reset = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        chk("midreset_busy", rx_busy, 0);
        chk("midreset_data", rxd_data, 8'h00);
        send_byte(8'h2E, 1'b1);
        drive_bit(1'b1, CPB);
        chk("after_reset_data", rxd_data, 8'h2E);

        // A few random frames
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drive_bit(1'b1, 2 * CPB);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("fe_all_seen", fe_exp, 0);
        chk("ready_total", ready_cnt, pushed);
        chk("fe_total", fe_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
